// File: rtl/mux_scan_ctrl.sv
// Sweeps the 4:1 mux selects 0..3, samples Mux_out SETTLE cycles after each change, and packs the word for a valid/ready sink.
// Latency: a sweep takes 4*(SETTLE+1) cycles; Valid rises in the cycle after that. Valid and Sample are held until Ready is seen.
// Build option: define CONTINUOUS_SCAN_EN to re-arm after every handshake once started (IDLE left only by reset).
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Mux_out,
    input  logic       Ready,
    output logic       Sel1,
    output logic       Sel0,
    output logic [3:0] Sample,
    output logic       Valid,
    output logic       Busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("mux_scan_ctrl: SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    state_t          state;
    logic [1:0]      channel;
    logic [1:0]      sel;
    logic [CW-1:0]   count;
    logic [2:0]      shadow;
    logic            rearm;

    assign {Sel1, Sel0} = sel;

`ifdef CONTINUOUS_SCAN_EN
    assign rearm = 1'b1;
`else
    assign rearm = Start;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            channel <= 2'd0;
            sel     <= 2'd0;
            count   <= '0;
            shadow  <= 3'b000;
            Sample  <= 4'b0000;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sel   <= 2'd0;
                    Valid <= 1'b0;
                    if (Start) begin
                        state   <= ST_SETTLE;
                        channel <= 2'd0;
                        count   <= '0;
                        Busy    <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (count == CNT_LAST) begin
                        state <= ST_CAPTURE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (channel != 2'd3) begin
                        shadow[channel] <= Mux_out;
                        channel         <= channel + 2'd1;
                        sel             <= channel + 2'd1;
                        count           <= '0;
                        state           <= ST_SETTLE;
                    end else begin
                        // Whole word lands at once so the sink never sees a mix of sweeps.
                        Sample <= {Mux_out, shadow};
                        Valid  <= 1'b1;
                        state  <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (Ready) begin
                        Valid   <= 1'b0;
                        sel     <= 2'd0;
                        channel <= 2'd0;
                        count   <= '0;
                        if (rearm) begin
                            state <= ST_SETTLE;
                        end else begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    sel   <= 2'd0;
                    Valid <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a sweep-position model plus directed vectors with literal expectations.
module tb_mux_scan_ctrl;

    localparam int S    = 2;
    localparam int PER  = S + 1;
    localparam int LAST = 4 * PER - 1;
`ifdef CONTINUOUS_SCAN_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic [3:0] in_vec;
    logic       mux_out;
    logic       sel1;
    logic       sel0;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model: a sweep is just a position 0..LAST; channel = pos / PER.
    bit         m_known  = 1'b0;
    bit         m_active = 1'b0;
    bit         m_hold   = 1'b0;
    int         m_pos    = 0;
    logic [3:0] m_shadow = 4'b0000;
    logic [3:0] m_sample = 4'b0000;

    always #5 clk = ~clk;

    assign mux_out = in_vec[{sel1, sel0}];

    mux_scan_ctrl #(.SETTLE(S)) dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Start  (start),
        .Mux_out(mux_out),
        .Ready  (ready),
        .Sel1   (sel1),
        .Sel0   (sel0),
        .Sample (sample),
        .Valid  (valid),
        .Busy   (busy)
    );

    function automatic int m_sel();
        if (m_active) return m_pos / PER;
        if (m_hold) return 3;
        return 0;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_hold   = 1'b0;
            m_pos    = 0;
            m_shadow = 4'b0000;
            m_sample = 4'b0000;
        end else if (m_active) begin
            if (m_pos % PER == S) m_shadow[m_pos / PER] = in_vec[m_pos / PER];
            if (m_pos == LAST) begin
                m_sample = m_shadow;
                m_active = 1'b0;
                m_hold   = 1'b1;
            end else begin
                m_pos++;
            end
        end else if (m_hold) begin
            if (ready) begin
                m_hold = 1'b0;
                if (start || CONT) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_pos    = 0;
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared against it mid-cycle.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_known) begin
            chk("model_sel", {2'b00, sel1, sel0}, 4'(m_sel()));
            chk("model_sample", sample, m_sample);
            chk("model_valid", {3'b000, valid}, {3'b000, m_hold});
            chk("model_busy", {3'b000, busy}, {3'b000, m_active | m_hold});
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        in_vec = 4'b0000;
        cyc();
        cyc();
        chk("reset_sel", {2'b00, sel1, sel0}, 4'd0);
        chk("reset_sample", sample, 4'b0000);
        chk("reset_valid", {3'b000, valid}, 4'd0);
        chk("reset_busy", {3'b000, busy}, 4'd0);
        rst_n = 1'b1;
        cyc();

`ifndef CONTINUOUS_SCAN_EN
        // Single sweep, In0..In3 = 1,0,1,1
        in_vec = 4'b1101;
        start  = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            start = 1'b0;
            chk("sweep_sel", {2'b00, sel1, sel0}, (c <= 3) ? 4'd0 : (c <= 6) ? 4'd1 : (c <= 9) ? 4'd2 : 4'd3);
            if (c < 13) chk("sweep_valid_early", {3'b000, valid}, 4'd0);
        end
        chk("sweep_valid_c13", {3'b000, valid}, 4'd1);
        chk("sweep_sample_c13", sample, 4'b1101);
        chk("model_pin_sample", m_sample, 4'b1101);

        // Backpressure
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("bp_valid", {3'b000, valid}, 4'd1);
            chk("bp_sample", sample, 4'b1101);
        end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        chk("bp_release_valid", {3'b000, valid}, 4'd0);
        chk("bp_release_busy", {3'b000, busy}, 4'd0);
        chk("bp_release_sel", {2'b00, sel1, sel0}, 4'd0);
        cyc();
        chk("idle_stays", {3'b000, busy}, 4'd0);

        // Back-to-back: sweep to HOLD, then Start+Ready together with new inputs
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            start = 1'b0;
        end
        chk("b2b_first_valid", {3'b000, valid}, 4'd1);
        in_vec = 4'b0110;
        start  = 1'b1;
        ready  = 1'b1;
        cyc();
        start = 1'b0;
        ready = 1'b0;
        chk("b2b_no_idle", {3'b000, busy}, 4'd1);
        chk("b2b_valid_drop", {3'b000, valid}, 4'd0);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 6) chk("b2b_sample_atomic", sample, 4'b1101);
            if (c < 12) chk("b2b_valid_early", {3'b000, valid}, 4'd0);
        end
        chk("b2b_valid", {3'b000, valid}, 4'd1);
        chk("b2b_sample", sample, 4'b0110);
        ready = 1'b1;
        cyc();
        ready = 1'b0;

        // Start pulses mid-sweep are ignored
        in_vec = 4'b1010;
        start  = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            cyc();
            start = (c == 2 || c == 7);
            if (c < 13) chk("ign_valid_early", {3'b000, valid}, 4'd0);
        end
        chk("ign_valid_c13", {3'b000, valid}, 4'd1);
        chk("ign_sample", sample, 4'b1010);
        ready = 1'b1;
        cyc();
        ready = 1'b0;

        // Reset in cycle 5 of a sweep
        in_vec = 4'b0111;
        start  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
        end
        rst_n = 1'b0;
        cyc();
        chk("midrst_sel", {2'b00, sel1, sel0}, 4'd0);
        chk("midrst_sample", sample, 4'b0000);
        chk("midrst_valid", {3'b000, valid}, 4'd0);
        chk("midrst_busy", {3'b000, busy}, 4'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("midrst_idle", {3'b000, busy}, 4'd0);
        end
`else
        // Continuous scanning: one Start, Ready tied high
        in_vec = 4'b1001;
        ready  = 1'b1;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 39; c++) begin
            cyc();
            chk("cont_busy", {3'b000, busy}, 4'd1);
            chk("cont_valid", {3'b000, valid}, (c % 13 == 12) ? 4'd1 : 4'd0);
            if (c % 13 == 12) begin
                chk("cont_sample", sample, in_vec);
                in_vec = in_vec + 4'd3;
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
